// File: rtl/vote_byte_encoder_if.sv
// Vote-in / byte-out handshake bundle for vote_byte_encoder.
// master = upstream vote source + UART side; slave = the encoder itself.
interface vote_byte_encoder_if #(
  parameter int NUM_VOTES = 10000
);
  localparam int CW = $clog2(NUM_VOTES);

  // Both handshakes: a transfer happens on a rising edge where valid && ready;
  // the producer holds its data stable while valid is high and ready is low.
  logic          vote_in;
  logic          vote_valid_in;
  logic          vote_ready_out;
  logic [7:0]    byte_out;
  logic          byte_valid_out;
  logic          byte_ready_in;
  logic [CW-1:0] sent_count_out;
  logic          done_out;

  modport master (
    output vote_in, vote_valid_in, byte_ready_in,
    input  vote_ready_out, byte_out, byte_valid_out, sent_count_out, done_out
  );

  modport slave (
    input  vote_in, vote_valid_in, byte_ready_in,
    output vote_ready_out, byte_out, byte_valid_out, sent_count_out, done_out
  );
endinterface

// File: rtl/vote_byte_encoder.sv
// Buffers single-bit votes and emits one repetition-coded byte per vote.
// Optional macro VOTE_TX_ERR_INJECT_EN flips one LFSR-selected bit per byte.
module vote_byte_encoder #(
  parameter int FIFO_DEPTH = 16,
  parameter int NUM_VOTES  = 10000
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  vote_byte_encoder_if.slave        bus,
  output logic                      state_dbg
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(NUM_VOTES);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  logic [0:0]          state;
  logic [FIFO_DEPTH-1:0] mem;
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [AW:0]         occ;
  logic [7:0]          byte_q;
  logic [7:0]          byte_nxt;
  logic [CW-1:0]       cnt;
  logic                done_q;
  logic                full;
  logic                empty;
  logic                push;
  logic                pop;
  logic                accept;

  // Ready is derived from registered occupancy only: a full FIFO refuses a
  // push even when a pop happens on the same edge.
  assign full   = (occ == (AW+1)'(FIFO_DEPTH));
  assign empty  = (occ == '0);
  assign push   = bus.vote_valid_in && !full;
  assign accept = (state == ST_SEND) && bus.byte_ready_in;
  assign pop    = !empty && ((state == ST_IDLE) || accept);

`ifdef VOTE_TX_ERR_INJECT_EN
  logic [7:0] lfsr;
  logic [7:0] lfsr_nxt;

  // Loads use the post-advance value so byte k always flips at step^k(seed).
  always_comb begin
    lfsr_nxt = lfsr;
    if (accept) lfsr_nxt = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) lfsr <= 8'hA5;
    else         lfsr <= lfsr_nxt;
  end

  always_comb byte_nxt = {8{mem[rd_ptr]}} ^ (8'h01 << lfsr_nxt[2:0]);
`else
  always_comb byte_nxt = {8{mem[rd_ptr]}};
`endif

  always_ff @(posedge clk_in) begin
    if (push) mem[wr_ptr] <= bus.vote_in;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state  <= ST_IDLE;
      byte_q <= 8'h00;
    end else begin
      if (pop) begin
        state  <= ST_SEND;
        byte_q <= byte_nxt;
      end else if (accept) begin
        state  <= ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        if (cnt == CW'(NUM_VOTES - 1)) begin
          cnt    <= '0;
          done_q <= 1'b1;
        end else begin
          cnt    <= cnt + CW'(1);
        end
      end
    end
  end

  assign bus.vote_ready_out = !full;
  assign bus.byte_out       = byte_q;
  assign bus.byte_valid_out = (state == ST_SEND);
  assign bus.sent_count_out = cnt;
  assign bus.done_out       = done_q;
  assign state_dbg          = state;
endmodule

// File: tb/tb_vote_byte_encoder.sv
// Directed + randomized bench for vote_byte_encoder against a queue-based
// transaction model; honours VOTE_TX_ERR_INJECT_EN when defined.
module tb_vote_byte_encoder;
  localparam int NV    = 4;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(NV);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic state_dbg;

  always #5 clk = ~clk;

  vote_byte_encoder_if #(.NUM_VOTES(NV)) bus ();

  vote_byte_encoder #(.FIFO_DEPTH(DEPTH), .NUM_VOTES(NV)) dut (
    .clk_in    (clk),
    .rst_in    (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Model: votes buffered in the FIFO, plus the byte currently offered.
  logic [0:0] exp_q[$];
  logic       m_held;
  logic       m_vote;
  logic [7:0] m_byte;
  int         m_cnt;
  logic       m_done;
  logic [7:0] m_lfsr;
  int         tests = 0;
  int         fails = 0;
  int         obs_accepts = 0;
  int         obs_done = 0;
  int         base;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_held = 1'b0;
    m_vote = 1'b0;
    m_byte = 8'h00;
    m_cnt  = 0;
    m_done = 1'b0;
    m_lfsr = 8'hA5;
  endtask

  // One clock: check outputs at the falling edge, then advance the model by
  // what the upcoming rising edge will do with the inputs now applied.
  task automatic tick();
    logic acc;
    logic psh;
    logic v;
    @(negedge clk);
    chk("byte_valid", bus.byte_valid_out, m_held);
    chk("byte_out", bus.byte_out, m_byte);
    chk("vote_ready", bus.vote_ready_out, exp_q.size() < DEPTH);
    chk("sent_count", bus.sent_count_out, m_cnt[CW-1:0]);
    chk("done", bus.done_out, m_done);
`ifdef VOTE_TX_ERR_INJECT_EN
    if (bus.byte_valid_out) begin
      chk("popcount", $countones(bus.byte_out), m_vote ? 7 : 1);
      chk("decode", $countones(bus.byte_out) > 4, m_vote);
    end
`endif
    if (bus.byte_valid_out && bus.byte_ready_in) obs_accepts++;
    if (bus.done_out) obs_done++;
    acc    = m_held && bus.byte_ready_in;
    psh    = bus.vote_valid_in && (exp_q.size() < DEPTH);
    m_done = 1'b0;
    if (acc) begin
      m_held = 1'b0;
      m_cnt  = m_cnt + 1;
      if (m_cnt == NV) begin
        m_cnt  = 0;
        m_done = 1'b1;
      end
      m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end
    if (!m_held && exp_q.size() > 0) begin
      v      = exp_q.pop_front();
      m_held = 1'b1;
      m_vote = v;
      m_byte = v ? 8'hFF : 8'h00;
`ifdef VOTE_TX_ERR_INJECT_EN
      m_byte = m_byte ^ (8'h01 << m_lfsr[2:0]);
`endif
    end
    if (psh) exp_q.push_back(bus.vote_in);
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    bus.vote_in       = 1'b0;
    bus.vote_valid_in = 1'b0;
    bus.byte_ready_in = 1'b0;
    rst_n = 1'b0;
    #3;
    chk("rst_byte_valid", bus.byte_valid_out, 1'b0);
    chk("rst_byte_out", bus.byte_out, 8'h00);
    chk("rst_sent_count", bus.sent_count_out, 0);
    chk("rst_done", bus.done_out, 1'b0);
    model_clear();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_vote(input logic v);
    bus.vote_in       = v;
    bus.vote_valid_in = 1'b1;
    tick();
    bus.vote_valid_in = 1'b0;
  endtask

  initial begin
    model_clear();
    do_reset();
    chk("ready_after_reset", bus.vote_ready_out, 1'b1);

    // Single vote, ready high: byte FF offered for one cycle, count 1.
    bus.byte_ready_in = 1'b1;
    push_vote(1'b1);
    chk("t1_not_yet_valid", bus.byte_valid_out, 1'b0);
    tick();
    chk("t1_valid", bus.byte_valid_out, 1'b1);
    chk("t1_byte", bus.byte_out, (m_byte));
    ticks(3);
    chk("t1_count", bus.sent_count_out, 1);

    // Ordered burst behind a 20-cycle stall.
    bus.byte_ready_in = 1'b0;
    base = obs_accepts;
    push_vote(1'b1);
    push_vote(1'b0);
    push_vote(1'b0);
    push_vote(1'b1);
    ticks(16);
    bus.byte_ready_in = 1'b1;
    ticks(6);
    chk("t2_accepts", obs_accepts - base, 4);

    // Fill to full with the consumer stalled; 17 votes are retained.
    bus.byte_ready_in = 1'b0;
    bus.vote_valid_in = 1'b1;
    for (int i = 0; i < 20; i++) begin
      bus.vote_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("t3_ready_low", bus.vote_ready_out, 1'b0);
    bus.vote_valid_in = 1'b0;
    base = obs_accepts;
    bus.byte_ready_in = 1'b1;
    ticks(22);
    chk("t3_drained", obs_accepts - base, 17);

    // Frame wrap: 9 bytes with a frame of 4 -> two done pulses, count ends 1.
    do_reset();
    base = obs_done;
    bus.byte_ready_in = 1'b1;
    bus.vote_valid_in = 1'b1;
    for (int i = 0; i < 9; i++) begin
      bus.vote_in = 1'($urandom_range(0, 1));
      tick();
    end
    bus.vote_valid_in = 1'b0;
    ticks(6);
    chk("t4_done_pulses", obs_done - base, 2);
    chk("t4_count", bus.sent_count_out, 1);

    // Reset with one byte in flight and 5 votes buffered.
    bus.byte_ready_in = 1'b0;
    for (int i = 0; i < 6; i++) push_vote(1'b1);
    tick();
    chk("t5_valid_before", bus.byte_valid_out, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_valid", bus.byte_valid_out, 1'b0);
    chk("t5_async_count", bus.sent_count_out, 0);
    do_reset();
    bus.byte_ready_in = 1'b1;
    base = obs_accepts;
    ticks(10);
    chk("t5_no_leftovers", obs_accepts - base, 0);

    // Randomized traffic on both handshakes, then drain.
    for (int i = 0; i < 400; i++) begin
      bus.vote_in       = 1'($urandom_range(0, 1));
      bus.vote_valid_in = ($urandom_range(0, 99) < 60);
      bus.byte_ready_in = ($urandom_range(0, 99) < 50);
      tick();
    end
    bus.vote_valid_in = 1'b0;
    bus.byte_ready_in = 1'b1;
    ticks(25);
    chk("rand_drained", bus.byte_valid_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
